// File: rtl/icmp_pipe_op_if.sv
// Handshake bundle for icmp_pipe_op: operation in, comparison result out.
// The slave modport is the pipeline's view; the master modport is the producer/consumer view.
interface icmp_pipe_op_if #(
  parameter int ParamBitWidth = 32,
  parameter int ParamTagWidth = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               pred;
  logic [ParamBitWidth-1:0] lhs;
  logic [ParamBitWidth-1:0] rhs;
  logic [ParamTagWidth-1:0] in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic                     ret;
  logic                     err;
  logic [ParamTagWidth-1:0] out_tag;
  logic [2:0]               occupancy;

  modport slave (
    input  in_valid, pred, lhs, rhs, in_tag, out_ready,
    output in_ready, out_valid, ret, err, out_tag, occupancy
  );

  modport master (
    output in_valid, pred, lhs, rhs, in_tag, out_ready,
    input  in_ready, out_valid, ret, err, out_tag, occupancy
  );
endinterface

// File: rtl/icmp_pipe_op.sv
// Pipelined integer compare: the predicate result is captured into stage 1 with its tag,
// then carried through delay stages that collapse bubbles independently.
module icmp_pipe_op #(
  parameter int ParamBitWidth = 32,
  parameter int ParamStages   = 2,
  parameter int ParamTagWidth = 8
) (
  input logic           clk,
  input logic           rst_n,
  icmp_pipe_op_if.slave bus
);
  localparam int Last = ParamStages - 1;

  logic [ParamStages-1:0]   valid_q;
  logic [ParamStages-1:0]   valid_d;
  logic [ParamStages-1:0]   load_s;
  logic [ParamStages-1:0]   ret_q;
  logic [ParamStages-1:0]   err_q;
  logic [ParamTagWidth-1:0] tag_q [ParamStages];
  logic [2:0]               occ_q;
  logic [2:0]               occ_d;
  logic [1:0]               cmp_s;

  // Returns {ret, err}; unknown predicates flag err and force ret low.
  function automatic logic [1:0] icmp_eval(input logic [3:0]               p,
                                           input logic [ParamBitWidth-1:0] a,
                                           input logic [ParamBitWidth-1:0] b);
    logic [1:0] r;
    case (p)
      4'd0:    r = {a == b, 1'b0};
      4'd1:    r = {a != b, 1'b0};
      4'd2:    r = {a >  b, 1'b0};
      4'd3:    r = {a >= b, 1'b0};
      4'd4:    r = {a <  b, 1'b0};
      4'd5:    r = {a <= b, 1'b0};
      4'd6:    r = {$signed(a) >  $signed(b), 1'b0};
      4'd7:    r = {$signed(a) >= $signed(b), 1'b0};
      4'd8:    r = {$signed(a) <  $signed(b), 1'b0};
      4'd9:    r = {$signed(a) <= $signed(b), 1'b0};
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  always_comb cmp_s = icmp_eval(bus.pred, bus.lhs, bus.rhs);

  // A stage may load when it, or any stage between it and the output, has room this cycle.
  always_comb begin : load_chain
    logic room;
    room   = bus.out_ready;
    load_s = {ParamStages{1'b0}};
    for (int i = Last; i >= 0; i--) begin
      room      = room | ~valid_q[i];
      load_s[i] = room;
    end
  end

  always_comb begin
    valid_d = valid_q;
    occ_d   = 3'd0;
    if (load_s[0]) begin
      valid_d[0] = bus.in_valid;
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int i = 1; i < ParamStages; i++) begin
      if (load_s[i]) begin
        valid_d[i] = valid_q[i-1];
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
    for (int i = 0; i < ParamStages; i++) begin
      occ_d = occ_d + {2'b00, valid_d[i]};
    end
  end

  // Payload only moves when real data arrives, so idle stages keep their last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {ParamStages{1'b0}};
      ret_q   <= {ParamStages{1'b0}};
      err_q   <= {ParamStages{1'b0}};
      occ_q   <= 3'd0;
      for (int i = 0; i < ParamStages; i++) begin
        tag_q[i] <= {ParamTagWidth{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      if (load_s[0] && bus.in_valid) begin
        ret_q[0] <= cmp_s[1];
        err_q[0] <= cmp_s[0];
        tag_q[0] <= bus.in_tag;
      end
      for (int i = 1; i < ParamStages; i++) begin
        if (load_s[i] && valid_q[i-1]) begin
          ret_q[i] <= ret_q[i-1];
          err_q[i] <= err_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign bus.in_ready  = load_s[0];
  assign bus.out_valid = valid_q[Last];
  assign bus.ret       = ret_q[Last];
  assign bus.err       = err_q[Last];
  assign bus.out_tag   = tag_q[Last];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_icmp_pipe_op.sv
// Scoreboard bench: directed vectors on a 2-stage pipe, random streams on 1- and 4-stage pipes.
module tb_icmp_pipe_op;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_r_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   got1        = 0;
  int   got4        = 0;
  bit   done1       = 1'b0;
  bit   done4       = 1'b0;

  logic [17:0] q2 [$];
  logic [17:0] q1 [$];
  logic [17:0] q4 [$];
  logic [17:0] e2, e1, e4;

  icmp_pipe_op_if #(.ParamBitWidth(8), .ParamTagWidth(8))  if2 ();
  icmp_pipe_op_if #(.ParamBitWidth(8), .ParamTagWidth(16)) if1 ();
  icmp_pipe_op_if #(.ParamBitWidth(8), .ParamTagWidth(16)) if4 ();

  icmp_pipe_op #(.ParamBitWidth(8), .ParamStages(2), .ParamTagWidth(8))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  icmp_pipe_op #(.ParamBitWidth(8), .ParamStages(1), .ParamTagWidth(16))
    dut1 (.clk(clk), .rst_n(rst_r_n), .bus(if1.slave));
  icmp_pipe_op #(.ParamBitWidth(8), .ParamStages(4), .ParamTagWidth(16))
    dut4 (.clk(clk), .rst_n(rst_r_n), .bus(if4.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no event within bound, want event", name);
  endtask

  // Reference compare: signed order via offset-binary (flip the sign bit, compare unsigned).
  function automatic logic [1:0] ref_icmp(input logic [3:0] p, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] sa, sb;
    sa = a ^ 8'h80;
    sb = b ^ 8'h80;
    case (p)
      4'd0:    return {a == b, 1'b0};
      4'd1:    return {a != b, 1'b0};
      4'd2:    return {a > b, 1'b0};
      4'd3:    return {!(a < b), 1'b0};
      4'd4:    return {b > a, 1'b0};
      4'd5:    return {!(a > b), 1'b0};
      4'd6:    return {sa > sb, 1'b0};
      4'd7:    return {!(sa < sb), 1'b0};
      4'd8:    return {sb > sa, 1'b0};
      4'd9:    return {!(sa > sb), 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  task automatic send2(input logic [3:0] p, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] tag, input logic r, input logic e);
    bit sent;
    sent = 1'b0;
    @(posedge clk); #1;
    if2.in_valid = 1'b1; if2.pred = p; if2.lhs = a; if2.rhs = b; if2.in_tag = tag;
    for (int g = 0; g < 20 && !sent; g++) begin
      @(negedge clk);
      if (if2.in_ready) begin
        q2.push_back({r, e, 8'h00, tag});
        sent = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!sent) flag("s2_accept_timeout");
  endtask

  task automatic idle2();
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && if2.out_valid && if2.out_ready) begin
      if (q2.size() == 0) begin
        check("s2_extra_result", {24'd0, if2.out_tag}, 32'hFFFF_FFFF);
      end else begin
        e2 = q2.pop_front();
        check("s2_result", {14'd0, if2.ret, if2.err, 8'd0, if2.out_tag}, {14'd0, e2});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_r_n && if1.out_valid && if1.out_ready) begin
      got1++;
      if (q1.size() == 0) begin
        check("s1_extra_result", {16'd0, if1.out_tag}, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        check("s1_result", {14'd0, if1.ret, if1.err, if1.out_tag}, {14'd0, e1});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_r_n && if4.out_valid && if4.out_ready) begin
      got4++;
      if (q4.size() == 0) begin
        check("s4_extra_result", {16'd0, if4.out_tag}, 32'hFFFF_FFFF);
      end else begin
        e4 = q4.pop_front();
        check("s4_result", {14'd0, if4.ret, if4.err, if4.out_tag}, {14'd0, e4});
      end
    end
  end

  initial begin
    if1.out_ready = 1'b0;
    if4.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if1.out_ready = ($urandom_range(1, 0) == 1);
      if4.out_ready = ($urandom_range(1, 0) == 1);
    end
  end

  initial begin : rand1
    logic [3:0] p;
    logic [7:0] a, b;
    bit sent;
    if1.in_valid = 1'b0; if1.pred = 4'd0; if1.lhs = 8'd0; if1.rhs = 8'd0; if1.in_tag = 16'd0;
    wait (rst_r_n);
    for (int n = 0; n < 10000; n++) begin
      p = 4'($urandom_range(15, 0));
      a = 8'($urandom);
      b = ($urandom_range(3, 0) == 0) ? a : 8'($urandom);
      sent = 1'b0;
      for (int g = 0; g < 1000 && !sent; g++) begin
        @(posedge clk); #1;
        if1.in_valid = ($urandom_range(1, 0) == 1);
        if1.pred = p; if1.lhs = a; if1.rhs = b; if1.in_tag = n[15:0];
        @(negedge clk);
        if (if1.in_valid && if1.in_ready) begin
          q1.push_back({ref_icmp(p, a, b), n[15:0]});
          sent = 1'b1;
        end
      end
      if (!sent) flag("s1_accept_timeout");
    end
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
    done1 = 1'b1;
  end

  initial begin : rand4
    logic [3:0] p;
    logic [7:0] a, b;
    bit sent;
    if4.in_valid = 1'b0; if4.pred = 4'd0; if4.lhs = 8'd0; if4.rhs = 8'd0; if4.in_tag = 16'd0;
    wait (rst_r_n);
    for (int n = 0; n < 10000; n++) begin
      p = 4'($urandom_range(15, 0));
      a = 8'($urandom);
      b = ($urandom_range(3, 0) == 0) ? a : 8'($urandom);
      sent = 1'b0;
      for (int g = 0; g < 1000 && !sent; g++) begin
        @(posedge clk); #1;
        if4.in_valid = ($urandom_range(1, 0) == 1);
        if4.pred = p; if4.lhs = a; if4.rhs = b; if4.in_tag = n[15:0];
        @(negedge clk);
        if (if4.in_valid && if4.in_ready) begin
          q4.push_back({ref_icmp(p, a, b), n[15:0]});
          sent = 1'b1;
        end
      end
      if (!sent) flag("s4_accept_timeout");
    end
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    done4 = 1'b1;
  end

  initial begin : directed
    logic exp_ret [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int acc;
    int cnt;
    bit fin;
    rst_n = 1'b0;
    rst_r_n = 1'b0;
    if2.in_valid = 1'b0; if2.pred = 4'd0; if2.lhs = 8'd0; if2.rhs = 8'd0;
    if2.in_tag = 8'd0; if2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, if2.out_valid}, 32'd0);
    check("rst_occupancy", {29'd0, if2.occupancy}, 32'd0);
    check("rst_ret_err_tag", {22'd0, if2.ret, if2.err, if2.out_tag}, 32'd0);
    #1;
    rst_n = 1'b1;
    rst_r_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, if2.in_ready}, 32'd1);

    // sgt 1 > -1, then ugt 1 > 255, with latency probed on the first one
    send2(4'd6, 8'h01, 8'hFF, 8'h11, 1'b1, 1'b0);
    idle2();
    @(negedge clk);
    check("lat_early", {31'd0, if2.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_hit", {31'd0, if2.out_valid}, 32'd1);
    send2(4'd2, 8'h01, 8'hFF, 8'h12, 1'b0, 1'b0);
    idle2();
    repeat (4) @(negedge clk);

    // all ten predicates back to back on 0x80 vs 0x7F
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send2(4'(i), 8'h80, 8'h7F, 8'(i), exp_ret[i], 1'b0);
        end
        idle2();
      end
      begin
        int first, last, n;
        first = -1; last = -1; n = 0;
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (if2.out_valid) begin
            if (first < 0) first = k;
            last = k;
            n++;
          end
        end
        check("b2b_count", n, 32'd10);
        check("b2b_contiguous", last - first + 1, 32'd10);
      end
    join
    repeat (3) @(negedge clk);

    send2(4'd12, 8'h3C, 8'h3C, 8'h5A, 1'b0, 1'b1);
    idle2();
    repeat (4) @(negedge clk);

    // stall the consumer while the producer keeps offering
    @(posedge clk); #1;
    if2.out_ready = 1'b0;
    if2.in_valid = 1'b1; if2.pred = 4'd4; if2.lhs = 8'd3; if2.rhs = 8'd5; if2.in_tag = 8'h20;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      if (if2.in_ready) begin
        q2.push_back({1'b1, 1'b0, 8'h00, 8'h20 + 8'(acc)});
        acc++;
      end
      @(posedge clk); #1;
      if2.in_tag = 8'h20 + 8'(acc);
    end
    check("stall_accepted", acc, 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, if2.in_ready}, 32'd0);
      check("stall_occupancy", {29'd0, if2.occupancy}, 32'd2);
      check("stall_hold", {22'd0, if2.out_valid, if2.ret, if2.out_tag}, {22'd0, 1'b1, 1'b1, 8'h20});
    end
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    if2.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_drained", q2.size(), 32'd0);

    // fill, then reset asynchronously mid-cycle
    @(posedge clk); #1;
    if2.out_ready = 1'b0;
    send2(4'd0, 8'h05, 8'h05, 8'h30, 1'b1, 1'b0);
    send2(4'd1, 8'h05, 8'h06, 8'h31, 1'b1, 1'b0);
    idle2();
    @(negedge clk);
    check("arst_full", {29'd0, if2.occupancy}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, if2.out_valid}, 32'd0);
    check("arst_occupancy", {29'd0, if2.occupancy}, 32'd0);
    q2.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    if2.out_ready = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, if2.in_ready}, 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (if2.out_valid) cnt++;
    end
    check("arst_no_stale", cnt, 32'd0);

    fin = 1'b0;
    for (int k = 0; k < 80000 && !fin; k++) begin
      @(negedge clk);
      fin = done1 && done4 && (q1.size() == 0) && (q4.size() == 0);
    end
    if (!fin) flag("random_drain_timeout");
    check("s1_received", got1, 32'd10000);
    check("s4_received", got4, 32'd10000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/icmp_pipe_op.md
ICMP_PIPE_OP -- requirements
Module: icmp_pipe_op

Interface
REQ-001 The block SHALL have parameter ParamBitWidth, default 32, meaning operand width in bits (legal 1..64).
REQ-002 The block SHALL have parameter ParamStages, default 2, meaning pipeline depth and latency in cycles (legal 1..4).
REQ-003 The block SHALL have parameter ParamTagWidth, default 8, meaning width of the sideband tag carried alongside each operation.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the operation this cycle.
REQ-008 The block SHALL have port pred, input, 4 bits: predicate code. 0=eq, 1=ne, 2=ugt, 3=uge, 4=ult, 5=ule, 6=sgt, 7=sge, 8=slt, 9=sle.
REQ-009 The block SHALL have ports lhs and rhs, input, ParamBitWidth bits each: the operands.
REQ-010 The block SHALL have port in_tag, input, ParamTagWidth bits: sideband tag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-013 The block SHALL have port ret, output, 1 bit: comparison result.
REQ-014 The block SHALL have port err, output, 1 bit: pred was 10..15 for this result.
REQ-015 The block SHALL have port out_tag, output, ParamTagWidth bits: in_tag of the operation that produced this result.
REQ-016 The block SHALL have port occupancy, output, 3 bits: count of valid stages in flight (0..ParamStages).

Function
REQ-017 An operation SHALL transfer in on a cycle where in_valid and in_ready are both 1; a result SHALL transfer out on a cycle where out_valid and out_ready are both 1.
REQ-018 The comparison SHALL be evaluated combinationally from lhs, rhs and pred, and captured into stage 1 together with err and in_tag.
REQ-019 Unsigned predicates SHALL treat operands as unsigned; signed predicates (6..9) SHALL treat operands as two's-complement of ParamBitWidth bits.
REQ-020 Stages 2..ParamStages SHALL be delay stages; each stage holds a valid bit plus {ret, err, tag}; the last stage drives out_valid, ret, err and out_tag.
REQ-021 Each stage SHALL load from its predecessor when it is empty or is unloading this cycle (per-stage bubble collapse); otherwise it SHALL hold its contents unchanged.
REQ-022 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 With out_ready held at 1, latency SHALL be exactly ParamStages cycles from input transfer to out_valid, and throughput SHALL be one operation per cycle.
REQ-024 While out_valid=1 and out_ready=0, ret, err and out_tag SHALL remain stable until the transfer.
REQ-025 For pred 10..15, ret SHALL be 0 and err SHALL be 1; for pred 0..9, err SHALL be 0.
REQ-026 occupancy SHALL equal the number of set stage valid bits, updated in the same cycle as the stage valid bits.
REQ-027 Results SHALL leave in the same order operations entered; no operation SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-028 Simultaneous input transfer and output transfer when the pipe is full SHALL be permitted; occupancy SHALL remain ParamStages.

Reset
REQ-029 While rst_n=0, all stage valid bits SHALL be 0, so out_valid=0 and occupancy=0; ret, err and out_tag SHALL be 0.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n deasserts.
REQ-031 Assertion of rst_n mid-operation SHALL discard all in-flight results immediately, without waiting for a clock edge.

Verification
REQ-032 The bench SHALL cover: ParamBitWidth=8, ParamStages=2, out_ready=1, pred=6 (sgt), lhs=0x01, rhs=0xFF -> ret=1 two cycles after transfer; pred=2 (ugt), same operands -> ret=0.
REQ-033 The bench SHALL cover: back-to-back operations over all pred 0..9 with lhs=0x80, rhs=0x7F and tags 0..9 -> ten results on consecutive cycles, tags in order, ret = 0,1,1,1,0,0,0,0,1,1.
REQ-034 The bench SHALL cover: out_ready=0 while in_valid=1 for 5 cycles -> exactly ParamStages operations accepted, in_ready=0 afterwards, occupancy=2, output stable; out_ready=1 -> drain in order.
REQ-035 The bench SHALL cover: pred=12, any operands -> ret=0, err=1 with its tag.
REQ-036 The bench SHALL cover: rst_n pulsed low with occupancy=2 -> out_valid=0 and occupancy=0 asynchronously; no stale result after release.
REQ-037 The bench SHALL cover: random in_valid/out_ready (50%) for 10000 operations with ParamStages in {1,4} -> output stream matches a reference model in order, with no loss or duplication.
